// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage with a one-entry IF/ID output register and a
//   one-entry skid register. Keeps the program counter, issues one word fetch
//   at a time over a valid/ready request channel, and hands each fetched word
//   with its PC to decode. A redirect flushes the stage and restarts fetch.
//
// Ports
//   clk           in   1  : clock, rising edge
//   rstN          in   1  : asynchronous active-low reset
//   imemReqValid  out  1  : fetch request valid (state REQ only)
//   imemReqAddr   out 32  : fetch byte address (word aligned)
//   imemReqReady  in   1  : memory accepts the request
//   imemRspValid  in   1  : response valid, one per accepted request
//   imemRspData   in  32  : fetched instruction word
//   stall         in   1  : decode cannot consume this cycle
//   redirect      in   1  : flush and restart fetch at redirectPc
//   redirectPc    in  32  : new fetch target, bits [1:0] forced to 0
//   instValid     out  1  : instOut/pcOut hold a valid instruction
//   instOut       out 32  : instruction word (NOP_INST when empty)
//   pcOut         out 32  : address of instOut
//   opcodeOut     out  7  : instOut[6:0]
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstN,
   output logic        imemReqValid,
   output logic [31:0] imemReqAddr,
   input  logic        imemReqReady,
   input  logic        imemRspValid,
   input  logic [31:0] imemRspData,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirectPc,
   output logic        instValid,
   output logic [31:0] instOut,
   output logic [31:0] pcOut,
   output logic [6:0]  opcodeOut
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      r_state,      w_state_nxt;
   logic [31:0] r_pc,         w_pc_nxt;
   logic        r_drop,       w_drop_nxt;
   logic [31:0] r_skid_inst,  w_skid_inst_nxt;
   logic [31:0] r_skid_pc,    w_skid_pc_nxt;
   logic        r_inst_valid, w_inst_valid_nxt;
   logic [31:0] r_inst,       w_inst_nxt;
   logic [31:0] r_pc_out,     w_pc_out_nxt;

   logic        w_consume;
   logic        w_outstanding;
   logic [31:0] w_redirect_pc;

   assign w_redirect_pc = redirectPc & ~32'h0000_0003;

   // Next-state and datapath decode.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned; a missing default here would infer a latch.
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_drop_nxt       = r_drop;
      w_skid_inst_nxt  = r_skid_inst;
      w_skid_pc_nxt    = r_skid_pc;
      w_inst_valid_nxt = r_inst_valid;
      w_inst_nxt       = r_inst;
      w_pc_out_nxt     = r_pc_out;

      w_consume = r_inst_valid && !stall;

      // A request is still in flight if we are waiting and its response has
      // not arrived this cycle, or a request is being accepted right now. A
      // response that lands in the redirect cycle closes the transaction, so
      // no drop is needed for it.
      w_outstanding = ((r_state == S_WAIT) && !imemRspValid) ||
                      ((r_state == S_REQ)  && imemReqReady);

      if (w_consume) begin
         w_inst_valid_nxt = 1'b0;
         w_inst_nxt       = NOP_INST;
      end

      case (r_state)
         S_IDLE: w_state_nxt = S_REQ;

         S_REQ: begin
            if (imemReqReady) w_state_nxt = S_WAIT;
         end

         S_WAIT: begin
            if (imemRspValid) begin
               if (r_drop) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = S_REQ;
               end else if (!r_inst_valid || w_consume) begin
                  w_inst_valid_nxt = 1'b1;
                  w_inst_nxt       = imemRspData;
                  w_pc_out_nxt     = r_pc;
                  w_pc_nxt         = r_pc + 32'd4;
                  w_state_nxt      = S_REQ;
               end else begin
                  // Output register is held by a stall: park the word.
                  w_skid_inst_nxt = imemRspData;
                  w_skid_pc_nxt   = r_pc;
                  w_pc_nxt        = r_pc + 32'd4;
                  w_state_nxt     = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            // In HOLD the output register is always full, so !stall means it
            // is consumed and the skid entry takes its place.
            if (!stall) begin
               w_inst_valid_nxt = 1'b1;
               w_inst_nxt       = r_skid_inst;
               w_pc_out_nxt     = r_skid_pc;
               w_state_nxt      = S_REQ;
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase

      // Redirect overrides everything above, including a held stall.
      if (redirect) begin
         w_pc_nxt         = w_redirect_pc;
         w_inst_valid_nxt = 1'b0;
         w_inst_nxt       = NOP_INST;
         w_skid_inst_nxt  = NOP_INST;
         w_skid_pc_nxt    = 32'h0;
         w_drop_nxt       = w_outstanding;
         w_state_nxt      = w_outstanding ? S_WAIT : S_REQ;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_drop       <= 1'b0;
         // NOTE: the skid data is reset along with its control even though
         // HOLD qualifies it; it is one entry and keeps outputs deterministic.
         r_skid_inst  <= NOP_INST;
         r_skid_pc    <= 32'h0;
         r_inst_valid <= 1'b0;
         r_inst       <= NOP_INST;
         r_pc_out     <= 32'h0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values computed above.
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_drop       <= w_drop_nxt;
         r_skid_inst  <= w_skid_inst_nxt;
         r_skid_pc    <= w_skid_pc_nxt;
         r_inst_valid <= w_inst_valid_nxt;
         r_inst       <= w_inst_nxt;
         r_pc_out     <= w_pc_out_nxt;
      end
   end

   assign imemReqValid = (r_state == S_REQ);
   assign imemReqAddr  = r_pc;
   assign instValid    = r_inst_valid;
   assign instOut      = r_inst;
   assign pcOut        = r_pc_out;
   assign opcodeOut    = r_inst[6:0];

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Directed bench for inst_fetch. A memory model answers accepted requests
//   after a programmable latency with an address-derived word. Stimulus pushes
//   the PCs that decode must receive into a scoreboard queue; a monitor pops
//   and compares every time the DUT hands an instruction to decode.
//   A second instance with RESET_PC = 32'hFFFF_FFFC checks PC wrap-around.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk;
   logic        rstN;
   logic        imemReqValid;
   logic [31:0] imemReqAddr;
   logic        imemReqReady;
   logic        imemRspValid;
   logic [31:0] imemRspData;
   logic        stall;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        instValid;
   logic [31:0] instOut;
   logic [31:0] pcOut;
   logic [6:0]  opcodeOut;

   // Second instance (wrap test)
   logic        req2Valid;
   logic [31:0] req2Addr;
   logic        req2Ready;
   logic        rsp2Valid;
   logic [31:0] rsp2Data;
   logic        stall2;
   logic        redirect2;
   logic [31:0] redirectPc2;
   logic        inst2Valid;
   logic [31:0] inst2Out;
   logic [31:0] pc2Out;
   logic [6:0]  opcode2Out;

   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;
   int   hs_cyc  = 0;
   int   mem_lat = 1;
   exp_t exp_q[$];

   logic [31:0] d2_addr [2];
   int          d2_cnt = 0;

   inst_fetch dut (
      .clk(clk), .rstN(rstN),
      .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
      .imemRspValid(imemRspValid), .imemRspData(imemRspData),
      .stall(stall), .redirect(redirect), .redirectPc(redirectPc),
      .instValid(instValid), .instOut(instOut), .pcOut(pcOut), .opcodeOut(opcodeOut)
   );

   inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rstN(rstN),
      .imemReqValid(req2Valid), .imemReqAddr(req2Addr), .imemReqReady(req2Ready),
      .imemRspValid(rsp2Valid), .imemRspData(rsp2Data),
      .stall(stall2), .redirect(redirect2), .redirectPc(redirectPc2),
      .instValid(inst2Valid), .instOut(inst2Out), .pcOut(pc2Out), .opcodeOut(opcode2Out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h0000_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: wait budget expired", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.inst = mem_word(pc);
      exp_q.push_back(e);
   endtask

   // Returns at the falling edge of the first accepted request.
   task automatic wait_req(input logic [31:0] exp_addr, input string name);
      int n = 0;
      @(negedge clk);
      while (!(imemReqValid && imemReqReady) && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) fail_now(name);
      else begin
         check(name, imemReqAddr, exp_addr);
         hs_cyc = cyc;
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (exp_q.size() != 0) fail_now(name);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_reqValid"}, {31'h0, imemReqValid}, 32'h0);
      check({tag, "_reqAddr"},  imemReqAddr, 32'h0);
      check({tag, "_instValid"}, {31'h0, instValid}, 32'h0);
      check({tag, "_instOut"},  instOut, NOP);
      check({tag, "_opcode"},   {25'h0, opcodeOut}, 32'h13);
      check({tag, "_pcOut"},    pcOut, 32'h0);
   endtask

   // Memory model for the main DUT: programmable response latency.
   initial begin
      logic        p_valid;
      logic [31:0] p_addr;
      int          p_cnt;
      p_valid = 1'b0;
      p_addr  = 32'h0;
      p_cnt   = 0;
      imemRspValid = 1'b0;
      imemRspData  = 32'h0;
      forever begin
         @(negedge clk);
         if (imemReqValid && imemReqReady) begin
            p_valid = 1'b1;
            p_addr  = imemReqAddr;
            p_cnt   = mem_lat;
         end
         @(posedge clk);
         #1;
         imemRspValid = 1'b0;
         if (p_valid) begin
            p_cnt--;
            if (p_cnt == 0) begin
               imemRspValid = 1'b1;
               imemRspData  = mem_word(p_addr);
               p_valid      = 1'b0;
            end
         end
      end
   end

   // Zero-wait memory for the wrap instance.
   initial begin
      logic        hs2;
      logic [31:0] a2;
      req2Ready   = 1'b1;
      stall2      = 1'b0;
      redirect2   = 1'b0;
      redirectPc2 = 32'h0;
      rsp2Valid   = 1'b0;
      rsp2Data    = 32'h0;
      forever begin
         @(negedge clk);
         hs2 = req2Valid && req2Ready;
         a2  = req2Addr;
         @(posedge clk);
         #1;
         rsp2Valid = hs2;
         rsp2Data  = mem_word(a2);
      end
   end

   // Record the first two fetch addresses of the wrap instance.
   initial begin
      int n = 0;
      @(posedge rstN);
      while (d2_cnt < 2 && n < 20) begin
         @(negedge clk);
         n++;
         if (req2Valid && req2Ready) begin
            d2_addr[d2_cnt] = req2Addr;
            d2_cnt++;
         end
      end
   end

   // Scoreboard monitor: compares each instruction decode consumes.
   initial begin
      exp_t e;
      logic [31:0] exp_inst;
      forever begin
         @(negedge clk);
         if (rstN && instValid && !stall) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_inst: got pc %h inst %h, expected none", pcOut, instOut);
            end else begin
               e = exp_q.pop_front();
               exp_inst = e.inst;
               check("mon_pcOut", pcOut, e.pc);
               check("mon_instOut", instOut, exp_inst);
               check("mon_opcode", {25'h0, opcodeOut}, {25'h0, exp_inst[6:0]});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t4;
      logic ok;

      rstN = 1'b0; imemReqReady = 1'b1; stall = 1'b0;
      redirect = 1'b0; redirectPc = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("rst");

      // 1: reset release, zero-wait fetches of 0x0, 0x4, 0x8
      step();
      rstN = 1'b1;
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
      @(negedge clk);
      check("idle_cycle_reqValid", {31'h0, imemReqValid}, 32'h0);
      @(negedge clk);
      check("first_req_valid", {31'h0, imemReqValid}, 32'h1);
      check("first_req_addr", imemReqAddr, 32'h0);
      wait_req(32'h4, "req_4");
      t4 = hs_cyc;
      wait_req(32'h8, "req_8");
      check("req_spacing", hs_cyc - t4, 32'd2);
      step();
      imemReqReady = 1'b0;
      drain("drain_basic");

      // 2: ready held low for 3 cycles
      ok = 1'b1;
      repeat (3) begin
         @(negedge clk);
         ok &= imemReqValid && (imemReqAddr == 32'hC) && !instValid;
      end
      check("ready_low_stable", {31'h0, ok}, 32'h1);
      push_exp(32'hC);
      step();
      imemReqReady = 1'b1;
      wait_req(32'hC, "req_c_after_ready");
      step();
      imemReqReady = 1'b0;
      drain("drain_ready");

      // 3: stall with a full output register fills the skid register
      step();
      stall = 1'b1;
      imemReqReady = 1'b1;
      push_exp(32'h10); push_exp(32'h14);
      wait_req(32'h10, "req_10");
      wait_req(32'h14, "req_14");
      step();
      step();
      ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         ok &= !imemReqValid && instValid && (pcOut == 32'h10);
      end
      check("hold_no_request", {31'h0, ok}, 32'h1);
      step();
      stall = 1'b0;
      imemReqReady = 1'b0;
      drain("drain_stall");

      // 4: redirect to 0x103 while a response is pending
      step();
      mem_lat = 3;
      imemReqReady = 1'b1;
      push_exp(32'h100);
      wait_req(32'h18, "req_18");
      step();
      redirect = 1'b1;
      redirectPc = 32'h103;
      mem_lat = 1;
      step();
      redirect = 1'b0;
      @(negedge clk);
      check("redir_wait_instValid", {31'h0, instValid}, 32'h0);
      check("redir_wait_instOut", instOut, NOP);
      wait_req(32'h100, "req_100");
      step();
      imemReqReady = 1'b0;
      drain("drain_redir_wait");

      // 5a: redirect coinciding with a request handshake
      step();
      imemReqReady = 1'b1;
      redirect = 1'b1;
      redirectPc = 32'h200;
      push_exp(32'h200);
      @(negedge clk);
      check("redir_hs_valid", {31'h0, imemReqValid}, 32'h1);
      check("redir_hs_addr", imemReqAddr, 32'h104);
      step();
      redirect = 1'b0;
      wait_req(32'h200, "req_200");
      step();
      imemReqReady = 1'b0;
      drain("drain_redir_hs");

      // 5b: redirect with stall held and a full output register
      step();
      stall = 1'b1;
      imemReqReady = 1'b1;
      mem_lat = 2;
      wait_req(32'h204, "req_204");
      wait_req(32'h208, "req_208");
      check("stall_full_valid", {31'h0, instValid}, 32'h1);
      check("stall_full_pc", pcOut, 32'h204);
      step();
      redirect = 1'b1;
      redirectPc = 32'h300;
      imemReqReady = 1'b0;
      push_exp(32'h300);
      step();
      redirect = 1'b0;
      stall = 1'b0;
      imemReqReady = 1'b1;
      mem_lat = 1;
      @(negedge clk);
      check("redir_stall_instValid", {31'h0, instValid}, 32'h0);
      check("redir_stall_instOut", instOut, NOP);
      wait_req(32'h300, "req_300");
      step();
      imemReqReady = 1'b0;
      drain("drain_redir_stall");

      // 6: reset pulse mid-WAIT, stale response afterwards
      step();
      imemReqReady = 1'b1;
      mem_lat = 3;
      wait_req(32'h304, "req_304");
      step();
      imemReqReady = 1'b0;
      rstN = 1'b0;
      @(negedge clk);
      check_reset("midrst");
      step();
      rstN = 1'b1;
      ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         ok &= !instValid && (imemReqAddr == 32'h0) && (instOut == NOP);
      end
      check("stale_rsp_ignored", {31'h0, ok}, 32'h1);
      step();
      mem_lat = 1;
      imemReqReady = 1'b1;
      push_exp(32'h0);
      wait_req(32'h0, "req_after_reset");
      step();
      imemReqReady = 1'b0;
      drain("drain_after_reset");

      // Wrap instance and final scoreboard state
      check("wrap_fetch_count", d2_cnt, 32'd2);
      check("wrap_first_addr", d2_addr[0], 32'hFFFF_FFFC);
      check("wrap_second_addr", d2_addr[1], 32'h0000_0000);
      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
